// File: rtl/ex_hazard_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_hazard_sequencer_if
//  Description : Pipeline-side bundle for the EX hazard sequencer: the OF
//                instruction, its valid flag, the EX branch outcome, and the
//                latch control outputs returned to the pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_hazard_sequencer_if;
    logic [31:0] of_instruction;
    logic        of_valid;
    logic        isBranchTaken;
    logic        stall_if;
    logic        stall_of;
    logic        bubble_ex;
    logic        flush_of;
    logic        hold_ex;
    logic        bubble_ma;
    logic        muldiv_busy;

    // Pipeline datapath side: presents the OF instruction, consumes controls
    modport master (
        output of_instruction,
        output of_valid,
        output isBranchTaken,
        input  stall_if,
        input  stall_of,
        input  bubble_ex,
        input  flush_of,
        input  hold_ex,
        input  bubble_ma,
        input  muldiv_busy
    );

    // Sequencer side: observes the OF instruction, drives the controls
    modport slave (
        input  of_instruction,
        input  of_valid,
        input  isBranchTaken,
        output stall_if,
        output stall_of,
        output bubble_ex,
        output flush_of,
        output hold_ex,
        output bubble_ma,
        output muldiv_busy
    );
endinterface
`default_nettype wire

// File: rtl/ex_hazard_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ex_hazard_sequencer
//  Description : Interlock / sequencing controller for the 5-stage SimpleRisc
//                pipeline. Decodes the OF instruction, tracks the EX and MA
//                destinations in a two-entry scoreboard, and generates the
//                stall, bubble, flush and EX-hold controls, including the
//                multi-cycle mul/div/mod hold and the taken-branch flush.
//                Optional macro EX_FORWARDING_EN: with the EX/MA->OF bypass
//                present, only load-use against EX stalls (1 cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_hazard_sequencer #(
    parameter int          MULDIV_CYCLES = 4,     // EX occupancy of mul/div/mod, 1..15
    parameter logic [3:0]  RA_REG        = 4'd15  // return-address register
) (
    input  wire logic            clk,
    input  wire logic            rst,
    ex_hazard_sequencer_if.slave bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [4:0] OP_CMP  = 5'b00101;
    localparam logic [4:0] OP_NOT  = 5'b01000;
    localparam logic [4:0] OP_MOV  = 5'b01001;
    localparam logic [4:0] OP_ASR  = 5'b01100;
    localparam logic [4:0] OP_NOP  = 5'b01101;
    localparam logic [4:0] OP_LD   = 5'b01110;
    localparam logic [4:0] OP_ST   = 5'b01111;
    localparam logic [4:0] OP_BEQ  = 5'b10000;
    localparam logic [4:0] OP_CALL = 5'b10011;
    localparam logic [4:0] OP_RET  = 5'b10100;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_MOD  = 5'b00100;

    localparam logic       MD_MULTI = (MULDIV_CYCLES > 1);
    localparam logic [3:0] MD_LOAD  = 4'(MULDIV_CYCLES - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Decode of the OF instruction
    // ------------------------------------------------------------------
    logic [4:0] w_op;
    logic       w_imm;
    logic [3:0] w_rd;
    logic [3:0] w_rs1;
    logic [3:0] w_rs2;

    assign w_op  = bus.of_instruction[31:27];
    assign w_imm = bus.of_instruction[26];
    assign w_rd  = bus.of_instruction[25:22];
    assign w_rs1 = bus.of_instruction[21:18];
    assign w_rs2 = bus.of_instruction[17:14];

    logic       w_rs1_en;     // rs1 field is a source
    logic       w_rs2_en;     // rs2 field is a source
    logic       w_rdsrc_en;   // rd field is a source (store data)
    logic       w_ra_en;      // RA_REG is a source (ret)
    logic       w_dest_en;    // instruction writes a register
    logic [3:0] w_dest;
    logic       w_is_ld;
    logic       w_muldiv;

    // Source/destination classification of the OF opcode
    always_comb begin
        w_rs1_en   = !((w_op == OP_NOT) || (w_op == OP_MOV) || (w_op == OP_NOP) ||
                       ((w_op >= OP_BEQ) && (w_op <= OP_CALL)));
        w_rs2_en   = !w_imm && (w_op <= OP_ASR);
        w_rdsrc_en = (w_op == OP_ST);
        w_ra_en    = (w_op == OP_RET);
        w_dest_en  = ((w_op <= OP_ASR) && (w_op != OP_CMP)) ||
                     (w_op == OP_LD) || (w_op == OP_CALL);
        w_dest     = (w_op == OP_CALL) ? RA_REG : w_rd;
        w_is_ld    = (w_op == OP_LD);
        w_muldiv   = (w_op >= OP_MUL) && (w_op <= OP_MOD);
    end

    // ------------------------------------------------------------------
    // Scoreboard (EX and MA entries) and multi-cycle FSM state
    // ------------------------------------------------------------------
    logic       ex_valid_q, ex_valid_d;
    logic [3:0] ex_dest_q,  ex_dest_d;
    logic       ex_is_ld_q, ex_is_ld_d;
    logic       ma_valid_q, ma_valid_d;
    logic [3:0] ma_dest_q,  ma_dest_d;
    logic       ma_is_ld_q, ma_is_ld_d;

    state_t     state_q;
    logic [3:0] md_cnt_q;
    logic       busy_q;

    // Does any live OF source name a given destination register?
    function automatic logic src_hit(input logic [3:0] d,
                                     input logic rs1_en, input logic [3:0] rs1,
                                     input logic rs2_en, input logic [3:0] rs2,
                                     input logic rd_en,  input logic [3:0] rd,
                                     input logic ra_en);
        return (rs1_en && (rs1 == d)) || (rs2_en && (rs2 == d)) ||
               (rd_en  && (rd  == d)) || (ra_en  && (RA_REG == d));
    endfunction

    logic w_hit_ex;
    logic w_hit_ma;
    logic w_hazard;

    // Match OF sources against the scoreboard and form the data hazard
    always_comb begin
        w_hit_ex = ex_valid_q && src_hit(ex_dest_q, w_rs1_en, w_rs1, w_rs2_en, w_rs2,
                                         w_rdsrc_en, w_rd, w_ra_en);
        w_hit_ma = ma_valid_q && src_hit(ma_dest_q, w_rs1_en, w_rs1, w_rs2_en, w_rs2,
                                         w_rdsrc_en, w_rd, w_ra_en);
`ifdef EX_FORWARDING_EN
        // Bypass covers everything except a load still in EX
        w_hazard = bus.of_valid && w_hit_ex && ex_is_ld_q;
`else
        w_hazard = bus.of_valid && (w_hit_ex || w_hit_ma);
`endif
    end

    // MA.is_ld is carried for visibility only; the MA match is unused
    // when the bypass handles everything past EX.
    logic w_unused;
`ifdef EX_FORWARDING_EN
    assign w_unused = ^{ma_is_ld_q, w_hit_ma};
`else
    assign w_unused = ^{ma_is_ld_q, ex_is_ld_q};
`endif

    // ------------------------------------------------------------------
    // Control outputs (all forced low while reset is asserted)
    // ------------------------------------------------------------------
    logic w_busy;
    logic w_flush;
    logic w_stall;
    logic w_bubble_ex;

    // Flush wins over a data stall; BUSY holds everything and bubbles MA
    always_comb begin
        w_busy      = busy_q && !rst;
        w_flush     = bus.isBranchTaken && !w_busy && !rst;
        w_stall     = w_busy || (w_hazard && !w_flush && !rst);
        w_bubble_ex = !w_busy && !rst && (w_flush || w_hazard);
    end

    assign bus.stall_if    = w_stall;
    assign bus.stall_of    = w_stall;
    assign bus.bubble_ex   = w_bubble_ex;
    assign bus.flush_of    = w_flush;
    assign bus.hold_ex     = w_busy;
    assign bus.bubble_ma   = w_busy;
    assign bus.muldiv_busy = w_busy;

    // An instruction actually moves from OF into EX this cycle
    logic w_issue;
    assign w_issue = !w_busy && bus.of_valid && !w_bubble_ex;

    // Scoreboard next state: advance when EX is free, else drain MA
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_dest_d  = ex_dest_q;
        ex_is_ld_d = ex_is_ld_q;
        ma_valid_d = 1'b0;
        ma_dest_d  = 4'd0;
        ma_is_ld_d = 1'b0;
        if (!w_busy) begin
            ma_valid_d = ex_valid_q;
            ma_dest_d  = ex_dest_q;
            ma_is_ld_d = ex_is_ld_q;
            if (w_issue) begin
                ex_valid_d = w_dest_en;
                ex_dest_d  = w_dest_en ? w_dest : 4'd0;
                ex_is_ld_d = w_dest_en && w_is_ld;
            end else begin
                ex_valid_d = 1'b0;
                ex_dest_d  = 4'd0;
                ex_is_ld_d = 1'b0;
            end
        end
    end

    // Scoreboard registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            ex_dest_q  <= 4'd0;
            ex_is_ld_q <= 1'b0;
            ma_valid_q <= 1'b0;
            ma_dest_q  <= 4'd0;
            ma_is_ld_q <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_dest_q  <= ex_dest_d;
            ex_is_ld_q <= ex_is_ld_d;
            ma_valid_q <= ma_valid_d;
            ma_dest_q  <= ma_dest_d;
            ma_is_ld_q <= ma_is_ld_d;
        end
    end

    // Multi-cycle FSM: BUSY covers the extra EX cycles of mul/div/mod
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            md_cnt_q <= 4'd0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_issue && w_muldiv && MD_MULTI) begin
                        state_q  <= ST_BUSY;
                        md_cnt_q <= MD_LOAD;
                        busy_q   <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (md_cnt_q <= 4'd1) begin
                        state_q  <= ST_IDLE;
                        md_cnt_q <= 4'd0;
                        busy_q   <= 1'b0;
                    end else begin
                        md_cnt_q <= md_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    md_cnt_q <= 4'd0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_hazard_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_hazard_sequencer
//  Description : Self-checking bench for ex_hazard_sequencer. A vector table
//                of {inputs, expected controls} is driven one per cycle;
//                expectations go into a queue and are compared against the
//                DUT outputs on the falling edge. Hand-written sequences
//                cover a dependent instruction waiting behind a mul.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_hazard_sequencer;

    logic clk;
    logic rst;

    ex_hazard_sequencer_if sif ();

    ex_hazard_sequencer #(
        .MULDIV_CYCLES (4),
        .RA_REG        (4'd15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word: {stall_if, stall_of, bubble_ex, flush_of,
    //                         hold_ex, bubble_ma, muldiv_busy}
    localparam logic [6:0] E0     = 7'b0000000;
    localparam logic [6:0] ESTALL = 7'b1110000;
    localparam logic [6:0] EBUSY  = 7'b1100111;
    localparam logic [6:0] EFLUSH = 7'b0011000;
`ifdef EX_FORWARDING_EN
    localparam logic [6:0] E_RAW  = E0;
`else
    localparam logic [6:0] E_RAW  = ESTALL;
`endif

    localparam logic [31:0] I_ADD1  = 32'h0048C000; // add r1,r2,r3
    localparam logic [31:0] I_SUB4  = 32'h09054000; // sub r4,r1,r5
    localparam logic [31:0] I_LD1   = 32'h74480000; // ld  r1,0[r2]
    localparam logic [31:0] I_MUL6  = 32'h119E0000; // mul r6,r7,r8
    localparam logic [31:0] I_ADD9  = 32'h02598000; // add r9,r6,r6
    localparam logic [31:0] I_CALL  = 32'h98000000; // call
    localparam logic [31:0] I_RET   = 32'hA0000000; // ret
    localparam logic [31:0] I_ADD0  = 32'h0008C000; // add r0,r2,r3
    localparam logic [31:0] I_ST0   = 32'h7C040000; // st  r0,0[r1]
    localparam logic [31:0] I_MOV5  = 32'h4D440000; // mov r5,#imm (rs1 field = r1)

    localparam int C_DRAIN_LIMIT = 20;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        valid;
        logic        br;
        logic [6:0]  exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [6:0] exp;
        string      name;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    int n_run  = 0;
    int n_fail = 0;
    int r_waited;
    logic [6:0] w_act_rst;

    function automatic void add_vec(input logic r, input logic [31:0] ins, input logic v,
                                    input logic b, input logic [6:0] e, input string nm);
        vec_t t;
        t.rst = r; t.instr = ins; t.valid = v; t.br = b; t.exp = e; t.name = nm;
        vecs.push_back(t);
    endfunction

    task automatic apply(input logic r, input logic [31:0] ins, input logic v,
                         input logic b, input logic [6:0] e, input string nm);
        exp_t x;
        @(posedge clk);
        #1;
        rst                = r;
        sif.of_instruction = ins;
        sif.of_valid       = v;
        sif.isBranchTaken  = b;
        x.exp  = e;
        x.name = nm;
        exp_q.push_back(x);
    endtask

    // Checker: pop one expectation per cycle and compare on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t       x;
            logic [6:0] act;
            x   = exp_q.pop_front();
            act = {sif.stall_if, sif.stall_of, sif.bubble_ex, sif.flush_of,
                   sif.hold_ex, sif.bubble_ma, sif.muldiv_busy};
            n_run++;
            if (act !== x.exp) begin
                n_fail++;
                $display("FAIL %s: got %b expected %b (si so bx fo hx bm mb)",
                         x.name, act, x.exp);
            end
        end
    end

    initial begin
        rst                = 1'b1;
        sif.of_instruction = 32'h0;
        sif.of_valid       = 1'b0;
        sif.isBranchTaken  = 1'b0;

        // Reset, then add -> sub RAW
        add_vec(1, 32'h0,  0, 0, E0,     "reset0");
        add_vec(1, 32'h0,  0, 0, E0,     "reset1");
        add_vec(0, I_ADD1, 1, 0, E0,     "first_after_reset");
        add_vec(0, I_SUB4, 1, 0, E_RAW,  "raw_stall_ex");
        add_vec(0, I_SUB4, 1, 0, E_RAW,  "raw_stall_ma");
        add_vec(0, I_SUB4, 1, 0, E0,     "raw_issue");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_a0");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_a1");
        // Load-use
        add_vec(0, I_LD1,  1, 0, E0,     "ld_issue");
        add_vec(0, I_SUB4, 1, 0, ESTALL, "loaduse_stall1");
        add_vec(0, I_SUB4, 1, 0, E_RAW,  "loaduse_stall2");
        add_vec(0, I_SUB4, 1, 0, E0,     "loaduse_issue");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_b0");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_b1");
        // Multi-cycle mul
        add_vec(0, I_MUL6, 1, 0, E0,     "mul_issue");
        add_vec(0, 32'h0,  0, 0, EBUSY,  "mul_busy1");
        add_vec(0, 32'h0,  0, 0, EBUSY,  "mul_busy2");
        add_vec(0, 32'h0,  0, 0, EBUSY,  "mul_busy3");
        add_vec(0, 32'h0,  0, 0, E0,     "mul_done");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_c0");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_c1");
        // Branch flush with a concurrent RAW hazard
        add_vec(0, I_ADD1, 1, 0, E0,     "br_producer");
        add_vec(0, I_SUB4, 1, 1, EFLUSH, "br_flush_over_stall");
        add_vec(0, I_SUB4, 0, 0, E0,     "bubble_no_hazard");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_d0");
        // Reset during BUSY
        add_vec(0, I_MUL6, 1, 0, E0,     "mul2_issue");
        add_vec(0, 32'h0,  0, 0, EBUSY,  "mul2_busy1");
        add_vec(1, 32'h0,  0, 0, E0,     "rst_mid_busy");
        add_vec(0, I_ADD9, 1, 0, E0,     "after_rst_dep");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_e0");
        // call writes RA, ret reads RA
        add_vec(0, I_CALL, 1, 0, E0,     "call_issue");
        add_vec(0, I_RET,  1, 0, E_RAW,  "ret_stall_ex");
        add_vec(0, I_RET,  1, 0, E_RAW,  "ret_stall_ma");
        add_vec(0, I_RET,  1, 0, E0,     "ret_issue");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_f0");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_f1");
        // r0 tracked, st reads rd
        add_vec(0, I_ADD0, 1, 0, E0,     "r0_producer");
        add_vec(0, I_ST0,  1, 0, E_RAW,  "st_rd_stall_ex");
        add_vec(0, I_ST0,  1, 0, E_RAW,  "st_rd_stall_ma");
        add_vec(0, I_ST0,  1, 0, E0,     "st_issue");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_g0");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_g1");
        // mov does not read rs1
        add_vec(0, I_ADD1, 1, 0, E0,     "mov_producer");
        add_vec(0, I_MOV5, 1, 0, E0,     "mov_no_rs1");
        add_vec(0, 32'h0,  0, 0, E0,     "drain_h0");

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].instr, vecs[i].valid, vecs[i].br,
                  vecs[i].exp, vecs[i].name);
        end

        // Dependent instruction waiting in OF behind a mul
        apply(0, I_MUL6, 1, 0, E0,    "dep_mul_issue");
        apply(0, I_ADD9, 1, 0, EBUSY, "dep_busy1");
        apply(0, I_ADD9, 1, 0, EBUSY, "dep_busy2");
        apply(0, I_ADD9, 1, 0, EBUSY, "dep_busy3");
        apply(0, I_ADD9, 1, 0, E_RAW, "dep_after_busy_ex");
        apply(0, I_ADD9, 1, 0, E_RAW, "dep_after_busy_ma");
        apply(0, I_ADD9, 1, 0, E0,    "dep_issue");
        apply(0, 32'h0,  0, 0, E0,    "dep_drain");

        // Bounded wait for the checker to consume every expectation
        r_waited = 0;
        while ((exp_q.size() != 0) && (r_waited < C_DRAIN_LIMIT)) begin
            @(posedge clk);
            r_waited++;
        end
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d expectations left after %0d cycles",
                     exp_q.size(), r_waited);
        end

        // Reset-state check: all outputs low while reset is asserted
        @(posedge clk);
        #1;
        rst                = 1'b1;
        sif.of_instruction = I_SUB4;
        sif.of_valid       = 1'b1;
        sif.isBranchTaken  = 1'b1;
        @(negedge clk);
        w_act_rst = {sif.stall_if, sif.stall_of, sif.bubble_ex, sif.flush_of,
                     sif.hold_ex, sif.bubble_ma, sif.muldiv_busy};
        n_run++;
        if (w_act_rst !== E0) begin
            n_fail++;
            $display("FAIL reset_outputs_low: got %b expected %b (si so bx fo hx bm mb)",
                     w_act_rst, E0);
        end
        @(posedge clk);
        #1;
        rst               = 1'b0;
        sif.of_valid      = 1'b0;
        sif.isBranchTaken = 1'b0;

        @(posedge clk);
        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_hazard_sequencer.md
Name: ex_hazard_sequencer

Overview:
- Interlock and sequencing controller for the 5-stage SimpleRisc pipeline (IF, OF, EX, MA, RW), centred on the execution stage.
- Decodes the instruction in OF and tracks destination registers of instructions in EX and MA with an internal scoreboard.
- Generates stall, bubble and flush controls for the IF/OF, OF/EX and EX/MA pipeline latches, including the branch flush.
- Holds EX for the extra cycles of multi-cycle mul/div/mod operations.

Parameters:
- MULDIV_CYCLES, 4, total EX occupancy (cycles) of mul/div/mod; legal range 1..15.
- RA_REG, 15, register index used by call (write) and ret (read).

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous active-high reset
- of_instruction  input  32  instruction currently in OF
- of_valid  input  1  OF holds a real instruction (0 = bubble)
- isBranchTaken  input  1  branch resolved taken in EX this cycle
- stall_if  output  1  hold PC and IF/OF latch
- stall_of  output  1  hold OF/EX latch input (OF instruction is not issued)
- bubble_ex  output  1  load a nop into the OF/EX latch
- flush_of  output  1  kill the IF/OF latch contents (branch flush)
- hold_ex  output  1  EX keeps its current instruction
- bubble_ma  output  1  load a nop into the EX/MA latch
- muldiv_busy  output  1  multi-cycle op occupying EX

Behaviour:
- Decode of of_instruction:
  - Field positions: opcode[31:27], I[26], rd[25:22], rs1[21:18], rs2[17:14].
  - Sources:
    - rs1 is read by all opcodes except not(01000), mov(01001), nop(01101), beq/bgt/b/call(10000-10011).
    - rs2 is read when I=0 by add..asr(00000-01100).
    - st(01111) also reads rd.
    - ret(10100) reads RA_REG.
  - Destination:
    - rd is written by add..asr except cmp(00101), and by ld(01110).
    - call writes RA_REG.
    - Everything else has no destination.
  - muldiv = opcode 00010/00011/00100.
- Scoreboard: two entries, EX and MA, each holding {valid, dest[3:0], is_ld}. Reset clears both entries.
- Each cycle, when hold_ex=0:
  - MA <= EX.
  - EX <= decoded OF entry, but an empty entry if bubble_ex=1 or of_valid=0.
- Each cycle, when hold_ex=1:
  - EX unchanged.
  - MA <= empty.
- The register file is write-before-read, so RW is never checked.
- Hazard (without forwarding): any OF source equals a valid EX.dest or MA.dest. Consequences:
  - Stall lasts up to 2 cycles.
  - During the stall: stall_if=1, stall_of=1, bubble_ex=1.
- Multi-cycle FSM, states IDLE and BUSY, with a 4-bit counter:
  - IDLE -> BUSY when a muldiv enters EX and MULDIV_CYCLES>1. The counter loads MULDIV_CYCLES-1.
  - In BUSY, all of these are 1: hold_ex, bubble_ma, stall_if, stall_of, muldiv_busy.
  - bubble_ex=0 while BUSY, because the OF/EX latch is simply held.
  - The counter decrements each cycle. BUSY -> IDLE when it reaches 1; hold_ex is low in the cycle after that.
  - With MULDIV_CYCLES=1, the FSM never leaves IDLE.
- Branch flush (isBranchTaken=1):
  - flush_of=1 and bubble_ex=1; the OF instruction is discarded.
  - stall_if=0 and stall_of=0: the target is fetched, and flush has priority over a concurrent hazard stall.
  - isBranchTaken while BUSY is impossible by construction (a branch is never muldiv) and is ignored.
- All outputs are combinational from the scoreboard, the FSM and the current inputs. Every output is 0 during reset and in the first cycle after reset, because the scoreboard is empty.
- Reset asserted mid-stall or mid-BUSY: the scoreboard clears and the FSM returns to IDLE on that edge.
- Destination r0 is tracked like any other register (no hardwired zero).

Optional Feature:
- Macro: EX_FORWARDING_EN.
- When defined:
  - The EX->OF and MA->OF bypass exists.
  - The only data stall is load-use: an OF source matches a valid EX.dest with EX.is_ld=1.
  - This stall is exactly 1 cycle.
  - Matches against MA, or against non-load EX entries, do not stall.
- When undefined: the full no-forwarding hazard rule above applies.

Test Plan:
- Reset: rst=1 for 2 cycles, then of_valid=1 with 0x0048C000 (add r1,r2,r3) -> all outputs 0; no stall in the first cycle after reset.
- RAW stall, no forwarding: 0x0048C000 followed by 0x09054000 (sub r4,r1,r5) -> stall_if=stall_of=bubble_ex=1 for 2 cycles, then sub issues. With EX_FORWARDING_EN: 0 stall cycles.
- Load-use: 0x74480000 (ld r1,0[r2]) followed by 0x09054000 -> exactly 1 stall cycle with EX_FORWARDING_EN; 2 cycles without.
- Multi-cycle: 0x119E0000 (mul r6,r7,r8) with MULDIV_CYCLES=4 -> hold_ex=bubble_ma=muldiv_busy=1 for 3 cycles after mul enters EX, then 0.
- Branch flush during stall: isBranchTaken=1 in the same cycle a RAW hazard is present -> flush_of=1, bubble_ex=1, stall_if=0, stall_of=0.
- Reset mid-BUSY: assert rst during the 2nd BUSY cycle -> next cycle muldiv_busy=0, hold_ex=0, scoreboard empty (no stall for a dependent instruction).
